// File: rtl/md5_block_gen.sv
// md5_block_gen: emits padded single-block MD5 messages of key || ASCII decimal counter
module md5_block_gen #(
  parameter int BLOCK_WIDTH = 512,
  parameter int MAX_KEY_BYTES = 16,
  parameter int COUNTER_DIGITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_valid,
  input  logic [7:0]             key_data,
  input  logic                   key_last,
  input  logic                   halt,
  input  logic                   md5_block_ready,
  output logic                   md5_block_valid,
  output logic [BLOCK_WIDTH-1:0] md5_block_data,
  output logic [31:0]            block_number,
  output logic [4:0]             key_len,
  output logic                   overflow
);
  localparam int DW = $clog2(COUNTER_DIGITS + 1);
  localparam int KW = $clog2(MAX_KEY_BYTES);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, HALT} state_t;
  state_t state;
  logic [7:0] key_mem [MAX_KEY_BYTES];
  logic [7:0] key_nxt [MAX_KEY_BYTES];
  logic [3:0] bcd [COUNTER_DIGITS];
  logic [3:0] bcd_inc [COUNTER_DIGITS];
  logic [DW-1:0] ndig, ndig_inc;
  logic [4:0] len_nxt;
  logic key_wr, xfer, carry, ovf_nxt;

  function automatic logic [BLOCK_WIDTH-1:0] build(
    input logic [7:0]    k [MAX_KEY_BYTES],
    input logic [4:0]    len,
    input logic [3:0]    d [COUNTER_DIGITS],
    input logic [DW-1:0] n
  );
    logic [7:0] b [64];
    logic [BLOCK_WIDTH-1:0] r;
    int l;
    l = int'(len) + int'(n);
    r = '0;
    for (int i = 0; i < 64; i++) b[i] = 8'h00;
    for (int i = 0; i < MAX_KEY_BYTES; i++) if (i < int'(len)) b[i] = k[i];
    for (int j = 0; j < COUNTER_DIGITS; j++) if (j < int'(n)) b[6'(l - 1 - j)] = {4'h3, d[j]};
    b[6'(l)] = 8'h80;
    b[56] = 8'(l * 8);
    b[57] = 8'(l >> 5);
    for (int i = 0; i < 64; i++) r[BLOCK_WIDTH-1-8*i -: 8] = b[i];
    return r;
  endfunction

  // key byte capture: write at key_len, saturating at MAX_KEY_BYTES
  always_comb begin
    key_wr = (state == IDLE || state == LOAD) && key_valid && !halt;
    xfer = md5_block_valid && md5_block_ready;
    len_nxt = key_len;
    for (int i = 0; i < MAX_KEY_BYTES; i++) key_nxt[i] = key_mem[i];
    if (key_wr && int'(key_len) < MAX_KEY_BYTES) begin
      key_nxt[key_len[KW-1:0]] = key_data;
      len_nxt = key_len + 5'd1;
    end
  end

  // BCD increment with rippled carry; all-9s grows one digit, or flags overflow
  always_comb begin
    carry = 1'b1;
    for (int j = 0; j < COUNTER_DIGITS; j++) begin
      bcd_inc[j] = bcd[j];
      if (carry && j < int'(ndig)) begin
        bcd_inc[j] = (bcd[j] == 4'd9) ? 4'd0 : bcd[j] + 4'd1;
        carry = (bcd[j] == 4'd9);
      end
    end
    for (int j = 0; j < COUNTER_DIGITS; j++) if (carry && j == int'(ndig)) bcd_inc[j] = 4'd1;
    ovf_nxt = carry && int'(ndig) == COUNTER_DIGITS;
    ndig_inc = ndig + {{(DW-1){1'b0}}, carry};
  end

  // control FSM with registered block, counter and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      md5_block_valid <= 1'b0;
      md5_block_data <= '0;
      block_number <= '0;
      key_len <= '0;
      overflow <= 1'b0;
      ndig <= DW'(1);
      for (int j = 0; j < COUNTER_DIGITS; j++) bcd[j] <= (j == 0) ? 4'd1 : 4'd0;
      for (int i = 0; i < MAX_KEY_BYTES; i++) key_mem[i] <= 8'h00;
    end else begin
      key_len <= len_nxt;
      key_mem <= key_nxt;
      case (state)
        IDLE, LOAD: begin
          if (halt) state <= HALT;
          else if (key_wr) begin
            state <= key_last ? RUN : LOAD;
            md5_block_valid <= key_last;
            if (key_last) begin
              md5_block_data <= build(key_nxt, len_nxt, bcd, ndig);
              block_number <= 32'd1;
            end
          end
        end
        RUN: begin
          if (xfer && (halt || ovf_nxt)) begin
            state <= HALT;
            md5_block_valid <= 1'b0;
            overflow <= ovf_nxt;
          end else if (xfer) begin
            bcd <= bcd_inc;
            ndig <= ndig_inc;
            block_number <= block_number + 32'd1;
            md5_block_data <= build(key_mem, key_len, bcd_inc, ndig_inc);
          end else if (halt) state <= DRAIN;
        end
        DRAIN: begin
          if (xfer) begin
            state <= HALT;
            md5_block_valid <= 1'b0;
            overflow <= ovf_nxt;
          end
        end
        HALT: state <= HALT;
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_md5_block_gen.sv
// tb_md5_block_gen: directed checks of key load, block layout, counter, handshake, halt, overflow, reset
module tb_md5_block_gen;
  logic clk = 1'b0, reset = 1'b0, key_valid = 1'b0, key_last = 1'b0, halt = 1'b0;
  logic ready = 1'b0, ready2 = 1'b1, halt2 = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic valid, ovf, valid2, ovf2;
  logic [511:0] data, data2, saved;
  logic [31:0] bn, bn2;
  logic [4:0] klen, klen2;
  int n_cmp = 0, n_err = 0, x2 = 0, max2 = 0;
  bit seq2_bad = 1'b0;

  always #5 clk = ~clk;

  md5_block_gen dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_data(key_data), .key_last(key_last),
    .halt(halt), .md5_block_ready(ready), .md5_block_valid(valid), .md5_block_data(data),
    .block_number(bn), .key_len(klen), .overflow(ovf)
  );

  md5_block_gen #(.COUNTER_DIGITS(2)) dut2 (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_data(key_data), .key_last(key_last),
    .halt(halt2), .md5_block_ready(ready2), .md5_block_valid(valid2), .md5_block_data(data2),
    .block_number(bn2), .key_len(klen2), .overflow(ovf2)
  );

  // sequence monitor for the two-digit instance: every transfer must carry the next number
  always @(posedge clk) if (reset && valid2 && ready2) begin
    if (bn2 != 32'(x2 + 1)) seq2_bad <= 1'b1;
    if (int'(bn2) > max2) max2 <= int'(bn2);
    x2 <= x2 + 1;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byt(input logic [511:0] d, input int i);
    return d[511-8*i -: 8];
  endfunction

  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) begin
      key_valid = 1'b1;
      key_data = s[i];
      key_last = (i == s.len() - 1);
      @(negedge clk);
    end
    key_valid = 1'b0;
    key_last = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_bn", bn, 0);
    chk("rst_klen", klen, 0);
    chk("rst_ovf", ovf, 0);
    reset = 1'b1;
    ready = 1'b1;
    load("abcdef");
    chk("b1_valid", valid, 1);
    chk("b1_head", data[511:456], 56'h61626364656631);
    chk("b1_pad", byt(data, 7), 8'h80);
    chk("b1_len", byt(data, 56), 8'h38);
    chk("b1_bn", bn, 1);
    chk("b1_klen", klen, 6);
    repeat (9) @(negedge clk);
    chk("b10_bn", bn, 10);
    chk("b10_d6", byt(data, 6), 8'h31);
    chk("b10_d7", byt(data, 7), 8'h30);
    chk("b10_pad", byt(data, 8), 8'h80);
    chk("b10_zero", byt(data, 9), 8'h00);
    chk("b10_len", byt(data, 56), 8'h40);
    @(negedge clk);
    chk("bp_bn11", bn, 11);
    saved = data;
    ready = 1'b0;
    @(negedge clk);
    chk("bp_stall1_bn", bn, 11);
    chk("bp_stall1_data", data, saved);
    @(negedge clk);
    chk("bp_stall2_bn", bn, 11);
    chk("bp_stall2_data", data, saved);
    chk("bp_stall_valid", valid, 1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("bp_bn12", bn, 12);
    chk("bp_d7", byt(data, 7), 8'h32);
    for (int i = 0; i < 300 && valid2 === 1'b1; i++) @(negedge clk);
    chk("ov_valid", valid2, 0);
    chk("ov_flag", ovf2, 1);
    chk("ov_bn", bn2, 99);
    chk("ov_xfers", x2, 99);
    chk("ov_seq", seq2_bad, 0);
    chk("ov_max", max2, 99);
    chk("main_noovf", ovf, 0);
    chk("main_hold_bn", bn, 12);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_data", data, 0);
    chk("arst_bn", bn, 0);
    chk("arst_klen", klen, 0);
    chk("arst_ovf2", ovf2, 0);
    @(negedge clk);
    reset = 1'b1;
    load("pqrstuv");
    chk("rl_head", data[511:448], 64'h7071727374757631);
    chk("rl_pad", byt(data, 8), 8'h80);
    chk("rl_len", byt(data, 56), 8'h40);
    chk("rl_bn", bn, 1);
    chk("rl_klen", klen, 7);
    ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("h_bn5", bn, 5);
    ready = 1'b0;
    halt = 1'b1;
    saved = data;
    @(negedge clk);
    halt = 1'b0;
    chk("h_drain_valid", valid, 1);
    chk("h_drain_bn", bn, 5);
    @(negedge clk);
    chk("h_drain2_valid", valid, 1);
    chk("h_drain2_data", data, saved);
    ready = 1'b1;
    @(negedge clk);
    chk("h_done_valid", valid, 0);
    chk("h_done_bn", bn, 5);
    load("xy");
    repeat (3) @(negedge clk);
    chk("h_stay_valid", valid, 0);
    chk("h_stay_bn", bn, 5);
    chk("h_key_ignored", klen, 7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
